// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register.
// Holds the operation-select enum and its width.
package shift_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    HOLD  = 3'd0,
    SHL   = 3'd1,
    SHR   = 3'd2,
    ROL   = 3'd3,
    ROR   = 3'd4,
    LOAD  = 3'd5,
    CLEAR = 3'd6,
    RSVD  = 3'd7
  } mode_e;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter: counts inc pulses up to MAX, clr zeroes.
// Ports: clk, reset (sync active-low), en, inc, clr -> cnt.
module sat_cnt #(
  parameter int MAX = 8,
  localparam int CW = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold/shift/rotate/load/clear by mode.
// Ports: clk, reset, en, mode, data, sin_l, sin_r -> q, sout_l, sout_r, cnt, drained.
module universal_shift_reg
  import shift_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              CW      = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  data,
  input  logic              sin_l,
  input  logic              sin_r,
  output logic [WIDTH-1:0]  q,
  output logic              sout_l,
  output logic              sout_r,
  output logic [CW-1:0]     cnt,
  output logic              drained
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             inc;
  logic             clr;

  always_comb begin
    q_d = q_q;
    inc = 1'b0;
    clr = 1'b0;
    unique case (mode_e'(mode))
      SHL: begin
        q_d = {q_q[WIDTH-2:0], sin_l};
        inc = 1'b1;
      end
      SHR: begin
        q_d = {sin_r, q_q[WIDTH-1:1]};
        inc = 1'b1;
      end
      ROL: begin
        q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        inc = 1'b1;
      end
      ROR: begin
        q_d = {q_q[0], q_q[WIDTH-1:1]};
        inc = 1'b1;
      end
      LOAD: begin
        q_d = data;
        clr = 1'b1;
      end
      CLEAR: begin
        q_d = RST_VAL;
        clr = 1'b1;
      end
      HOLD, RSVD: begin
        q_d = q_q;
      end
      default: begin
        q_d = q_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q <= RST_VAL;
    end else if (en) begin
      q_q <= q_d;
    end
  end

  sat_cnt #(
    .MAX (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .inc   (inc),
    .clr   (clr),
    .cnt   (cnt)
  );

  assign q       = q_q;
  assign sout_l  = q_q[WIDTH-1];
  assign sout_r  = q_q[0];
  assign drained = (cnt == CW'(WIDTH));

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=8).
// Directed scenarios followed by random steps against an arithmetic model.
module tb_universal_shift_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic [7:0] data;
  logic       sin_l;
  logic       sin_r;
  logic [7:0] q;
  logic       sout_l;
  logic       sout_r;
  logic [3:0] cnt;
  logic       drained;

  int checks = 0;
  int errors = 0;
  int mq = 0;
  int mc = 0;

  universal_shift_reg #(
    .WIDTH   (8),
    .RST_VAL (8'h00)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .data    (data),
    .sin_l   (sin_l),
    .sin_r   (sin_r),
    .q       (q),
    .sout_l  (sout_l),
    .sout_r  (sout_r),
    .cnt     (cnt),
    .drained (drained)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: register value as an integer 0..255, count as 0..8.
  task automatic model(bit r, bit e, int md, int d, bit sl, bit sr);
    if (!r) begin
      mq = 0;
      mc = 0;
    end else if (e) begin
      case (md)
        1: mq = ((mq * 2) + sl) % 256;
        2: mq = (mq / 2) + (sr ? 128 : 0);
        3: mq = ((mq * 2) % 256) + (mq / 128);
        4: mq = (mq / 2) + ((mq % 2) * 128);
        5: mq = d;
        6: mq = 0;
        default: ;
      endcase
      if (md >= 1 && md <= 4) mc = (mc < 8) ? mc + 1 : 8;
      if (md == 5 || md == 6) mc = 0;
    end
  endtask

  task automatic step(bit r, bit e, int md, int d, bit sl, bit sr);
    reset = r;
    en    = e;
    mode  = md[2:0];
    data  = d[7:0];
    sin_l = sl;
    sin_r = sr;
    @(posedge clk);
    model(r, e, md, d, sl, sr);
    #1;
    chk("m_q", 64'(q), 64'(mq));
    chk("m_cnt", 64'(cnt), 64'(mc));
    chk("m_drained", 64'(drained), 64'(mc == 8));
    chk("m_sout_l", 64'(sout_l), 64'(mq / 128));
    chk("m_sout_r", 64'(sout_r), 64'(mq % 2));
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b1;
    mode  = 3'd5;
    data  = 8'hFF;
    sin_l = 1'b0;
    sin_r = 1'b0;

    step(0, 1, 5, 'hFF, 0, 0);
    step(0, 1, 5, 'hFF, 0, 0);
    chk("rst_q", 64'(q), 64'h00);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_drained", 64'(drained), 64'd0);

    step(1, 1, 5, 'hA5, 0, 0);
    step(1, 1, 1, 0, 1, 0);
    chk("shl_q", 64'(q), 64'h4B);
    chk("shl_sout_l", 64'(sout_l), 64'd0);
    chk("shl_cnt", 64'(cnt), 64'd1);

    step(1, 1, 5, 'h81, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 4, 0, 0, 0);
    chk("ror8_q", 64'(q), 64'h81);
    chk("ror8_cnt", 64'(cnt), 64'd8);
    chk("ror8_drained", 64'(drained), 64'd1);
    step(1, 1, 4, 0, 0, 0);
    chk("ror9_q", 64'(q), 64'hC0);
    chk("ror9_cnt", 64'(cnt), 64'd8);

    step(1, 1, 5, 'h3C, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 2, 0, 0, 1);
    chk("en0_q", 64'(q), 64'h3C);
    chk("en0_cnt", 64'(cnt), 64'd0);
    step(1, 1, 2, 0, 0, 1);
    chk("shr_q", 64'(q), 64'h9E);

    step(1, 1, 5, 'h5A, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 3, 0, 0, 0);
    chk("mid_cnt", 64'(cnt), 64'd5);
    step(0, 1, 5, 'hEE, 0, 0);
    chk("midrst_q", 64'(q), 64'h00);
    chk("midrst_cnt", 64'(cnt), 64'd0);

    step(1, 1, 5, 'h12, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 7, 'hFF, 1, 1);
    chk("rsvd_q", 64'(q), 64'h12);
    chk("rsvd_cnt", 64'(cnt), 64'd0);
    step(1, 1, 1, 0, 1, 0);
    step(1, 1, 6, 'hFF, 0, 0);
    chk("clr_q", 64'(q), 64'h00);
    chk("clr_cnt", 64'(cnt), 64'd0);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 24) != 0,
           $urandom_range(0, 4) != 0,
           $urandom_range(0, 7),
           $urandom_range(0, 255),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
